// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the fetch/load-store memory bus arbiter:
// FSM state encodings, default timeout and the bus request bundle.
package imem_dmem_arbiter_pkg;

  localparam int ARB_TIMEOUT_DEF = 16;
  localparam int ARB_TMO_W_DEF   = 5;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUS_I = 2'd1,
    ARB_BUS_D = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } bus_req_t;

  function automatic bus_req_t ifetch_req(
    input logic [31:0] addr
  );
    bus_req_t r;
    r.we    = 1'b0;
    r.addr  = addr;
    r.wdata = '0;
    r.sel   = 4'hF;
    return r;
  endfunction

  function automatic bus_req_t data_req(
    input logic        we,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [3:0]  sel
  );
    bus_req_t r;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    r.sel   = sel;
    return r;
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Bus-cycle timeout counter: clear, count-enable and an expired flag
// raised on the last permitted cycle of a transaction.
module arb_timeout_ctr #(
  parameter int TMO_W = 5,
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

  logic [TMO_W-1:0] r_count;
  logic             w_expired;

  assign w_expired = (r_count == LAST);
  assign o_expired = w_expired;

  // Saturate at LAST so a stuck enable can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Single-port memory bus arbiter between fetch (I) and load/store (D).
// Define ARB_ROUND_ROBIN_EN for round-robin; default is data-first.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEF,
  parameter int TMO_W          = ARB_TMO_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_Istb,
  input  logic [31:0] i_Iaddr,
  output logic        o_Iack,
  output logic [31:0] o_Iinst,
  output logic        o_Ierr,
  input  logic        i_Dstb,
  input  logic        i_Dwe,
  input  logic [31:0] i_Daddr,
  input  logic [31:0] i_Dwdata,
  input  logic [3:0]  i_Dsel,
  output logic        o_Dack,
  output logic [31:0] o_Drdata,
  output logic        o_Derr,
  output logic        o_Mem_stb,
  output logic        o_Mem_we,
  output logic [31:0] o_Mem_addr,
  output logic [31:0] o_Mem_wdata,
  output logic [3:0]  o_Mem_sel,
  input  logic [31:0] i_Mem_rdata,
  input  logic        i_Mem_ack
);

  arb_state_e r_state;
  bus_req_t   r_bus;
  logic       r_mem_stb;
  logic       r_live;
  logic       r_iack;
  logic       r_ierr;
  logic       r_dack;
  logic       r_derr;
  logic [31:0] r_iinst;
  logic [31:0] r_drdata;

  logic       w_grant_d;
  logic       w_grant_i;
  logic       w_on_bus;
  logic       w_is_d;
  logic       w_cur_stb;
  logic       w_deliver;
  logic       w_expired;
  bus_req_t   w_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  assign w_grant_d = i_Dstb & (~i_Istb | ~r_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (r_state == ARB_IDLE && (i_Dstb || i_Istb)) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = i_Dstb;
`endif

  assign w_grant_i = i_Istb & ~w_grant_d;

  assign w_req = w_grant_d
    ? data_req(i_Dwe, i_Daddr, i_Dwdata, i_Dsel)
    : ifetch_req(i_Iaddr);

  assign w_on_bus  = (r_state == ARB_BUS_I) ||
                     (r_state == ARB_BUS_D);
  assign w_is_d    = (r_state == ARB_BUS_D);
  assign w_cur_stb = w_is_d ? i_Dstb : i_Istb;

  // A requester that let go of stb at any point forfeits its pulse.
  assign w_deliver = r_live & w_cur_stb;

  arb_timeout_ctr #(
    .TMO_W (TMO_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (~w_on_bus),
    .i_en      (w_on_bus),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_bus     <= '0;
      r_mem_stb <= 1'b0;
      r_live    <= 1'b0;
      r_iack    <= 1'b0;
      r_ierr    <= 1'b0;
      r_dack    <= 1'b0;
      r_derr    <= 1'b0;
      r_iinst   <= '0;
      r_drdata  <= '0;
    end else begin
      r_iack <= 1'b0;
      r_ierr <= 1'b0;
      r_dack <= 1'b0;
      r_derr <= 1'b0;
      unique case (r_state)
        ARB_IDLE: begin
          unique case (1'b1)
            w_grant_d: begin
              r_state   <= ARB_BUS_D;
              r_bus     <= w_req;
              r_mem_stb <= 1'b1;
              r_live    <= 1'b1;
            end
            w_grant_i: begin
              r_state   <= ARB_BUS_I;
              r_bus     <= w_req;
              r_mem_stb <= 1'b1;
              r_live    <= 1'b1;
            end
            default: ;
          endcase
        end
        ARB_BUS_I, ARB_BUS_D: begin
          if (!w_cur_stb) begin
            r_live <= 1'b0;
          end
          // Ack is checked first so a last-cycle ack still succeeds.
          if (i_Mem_ack) begin
            r_state   <= ARB_RESP;
            r_mem_stb <= 1'b0;
            if (w_deliver && w_is_d) begin
              r_dack <= 1'b1;
              if (!r_bus.we) begin
                r_drdata <= i_Mem_rdata;
              end
            end else if (w_deliver) begin
              r_iack  <= 1'b1;
              r_iinst <= i_Mem_rdata;
            end
          end else if (w_expired) begin
            r_state   <= ARB_RESP;
            r_mem_stb <= 1'b0;
            if (w_deliver && w_is_d) begin
              r_derr <= 1'b1;
            end else if (w_deliver) begin
              r_ierr <= 1'b1;
            end
          end
        end
        ARB_RESP: begin
          r_state <= ARB_IDLE;
          r_live  <= 1'b0;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_Mem_stb   = r_mem_stb;
  assign o_Mem_we    = r_bus.we;
  assign o_Mem_addr  = r_bus.addr;
  assign o_Mem_wdata = r_bus.wdata;
  assign o_Mem_sel   = r_bus.sel;

  assign o_Iack   = r_iack;
  assign o_Ierr   = r_ierr;
  assign o_Iinst  = r_iinst;
  assign o_Dack   = r_dack;
  assign o_Derr   = r_derr;
  assign o_Drdata = r_drdata;

endmodule
